// File: rtl/block_nest_pkg.sv
// Shared definitions for the begin/end nesting checker.
// Contents: 4-bit FSM state encoding, ASCII character constants,
// and a lowercase helper used by the character classifier.
package block_nest_pkg;

  localparam int unsigned ST_W = 4;
  localparam int unsigned CH_W = 8;

  // FSM state encoding
  localparam logic [ST_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [ST_W-1:0] ST_WORD    = 4'd1;
  localparam logic [ST_W-1:0] ST_B       = 4'd2;
  localparam logic [ST_W-1:0] ST_BE      = 4'd3;
  localparam logic [ST_W-1:0] ST_BEG     = 4'd4;
  localparam logic [ST_W-1:0] ST_BEGI    = 4'd5;
  localparam logic [ST_W-1:0] ST_BEGIN   = 4'd6;
  localparam logic [ST_W-1:0] ST_BEGIN_O = 4'd7;
  localparam logic [ST_W-1:0] ST_E       = 4'd8;
  localparam logic [ST_W-1:0] ST_EN      = 4'd9;
  localparam logic [ST_W-1:0] ST_END     = 4'd10;
  localparam logic [ST_W-1:0] ST_END_U   = 4'd11;

  // Character codes
  localparam logic [CH_W-1:0] CH_SPACE = 8'h20;
  localparam logic [CH_W-1:0] CH_CASE  = 8'h20;
  localparam logic [CH_W-1:0] CH_UP_A  = 8'h41;
  localparam logic [CH_W-1:0] CH_UP_Z  = 8'h5A;
  localparam logic [CH_W-1:0] CH_LO_A  = 8'h61;
  localparam logic [CH_W-1:0] CH_LO_Z  = 8'h7A;
  localparam logic [CH_W-1:0] CH_DIG_0 = 8'h30;
  localparam logic [CH_W-1:0] CH_DIG_9 = 8'h39;
  localparam logic [CH_W-1:0] CH_UNDER = 8'h5F;
  localparam logic [CH_W-1:0] CH_B     = 8'h62;
  localparam logic [CH_W-1:0] CH_D     = 8'h64;
  localparam logic [CH_W-1:0] CH_E     = 8'h65;
  localparam logic [CH_W-1:0] CH_G     = 8'h67;
  localparam logic [CH_W-1:0] CH_I     = 8'h69;
  localparam logic [CH_W-1:0] CH_N     = 8'h6E;

  // Fold upper-case ASCII letters onto lower case; other codes pass through
  function automatic logic [CH_W-1:0] to_lower(input logic [CH_W-1:0] c);
    if (c >= CH_UP_A && c <= CH_UP_Z) return c | CH_CASE;
    return c;
  endfunction

endpackage

// File: rtl/block_nest_charclass.sv
// Combinational character classifier for the nesting checker.
// Ports: in (ASCII code) -> is_space, is_letter, lower (case-folded code).
// Build option: BLOCK_NEST_DIGIT_EN makes digits and '_' letter-class,
// otherwise they are ignored like any other non-letter code.
module block_nest_charclass
  import block_nest_pkg::*;
(
  input  logic [CH_W-1:0] in,
  output logic            is_space,
  output logic            is_letter,
  output logic [CH_W-1:0] lower
);

  logic alpha;

  assign lower    = to_lower(in);
  assign is_space = (in == CH_SPACE);
  assign alpha    = (lower >= CH_LO_A) && (lower <= CH_LO_Z);

`ifdef BLOCK_NEST_DIGIT_EN
  // Identifier characters glue onto a keyword and cancel it
  assign is_letter = alpha || ((in >= CH_DIG_0) && (in <= CH_DIG_9)) || (in == CH_UNDER);
`else
  assign is_letter = alpha;
`endif

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker over an ASCII character stream.
// Ports: clk, reset (async, active-high), in[7:0], in_valid ->
//   result (combinational balance indication), depth[CNT_W-1:0],
//   err_underflow / err_overflow (sticky until reset).
// Build option: BLOCK_NEST_DIGIT_EN (handled in block_nest_charclass).
module block_nest_checker
  import block_nest_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_DEPTH = 2**CNT_W - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH_W-1:0]  in,
  input  logic             in_valid,
  output logic             result,
  output logic [CNT_W-1:0] depth,
  output logic             err_underflow,
  output logic             err_overflow
);

  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [ST_W-1:0]  state, state_nx;
  logic [CNT_W-1:0] depth_nx;
  logic             err_u_nx, err_o_nx;
  logic             is_space, is_letter;
  logic [CH_W-1:0]  lower;
  logic             frozen;

  block_nest_charclass u_charclass (
    .in        (in),
    .is_space  (is_space),
    .is_letter (is_letter),
    .lower     (lower)
  );

  // Any error latches the depth where it was
  assign frozen = err_underflow | err_overflow;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      depth         <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state         <= state_nx;
      depth         <= depth_nx;
      err_underflow <= err_u_nx;
      err_overflow  <= err_o_nx;
    end
  end

  // Keyword recogniser; a trailing keyword is counted speculatively and
  // undone if another letter follows before the delimiting space
  always_comb begin
    state_nx = state;
    depth_nx = depth;
    err_u_nx = err_underflow;
    err_o_nx = err_overflow;
    if (in_valid && is_space) begin
      state_nx = ST_IDLE;
      if (state == ST_BEGIN_O) err_o_nx = 1'b1;
      if (state == ST_END_U)   err_u_nx = 1'b1;
    end else if (in_valid && is_letter) begin
      state_nx = ST_WORD;
      case (state)
        ST_IDLE: begin
          if (lower == CH_B)      state_nx = ST_B;
          else if (lower == CH_E) state_nx = ST_E;
        end
        ST_B:   if (lower == CH_E) state_nx = ST_BE;
        ST_BE:  if (lower == CH_G) state_nx = ST_BEG;
        ST_BEG: if (lower == CH_I) state_nx = ST_BEGI;
        ST_BEGI: begin
          if (lower == CH_N) begin
            if (depth < MAX_D) begin
              state_nx = ST_BEGIN;
              if (!frozen) depth_nx = depth + ONE;
            end else begin
              state_nx = ST_BEGIN_O;
            end
          end
        end
        ST_E:   if (lower == CH_N) state_nx = ST_EN;
        ST_EN: begin
          if (lower == CH_D) begin
            if (depth != '0) begin
              state_nx = ST_END;
              if (!frozen) depth_nx = depth - ONE;
            end else begin
              state_nx = ST_END_U;
            end
          end
        end
        ST_BEGIN: if (!frozen) depth_nx = depth - ONE;
        ST_END:   if (!frozen) depth_nx = depth + ONE;
        default:  state_nx = ST_WORD;
      endcase
    end
  end

  assign result = (depth == '0) && (state != ST_END_U) && !err_underflow && !err_overflow;

endmodule

// File: tb/tb_block_nest_checker.sv
// Self-checking bench for block_nest_checker: a default-width instance and
// a CNT_W=2 / MAX_DEPTH=3 instance share one input stream.
module tb_block_nest_checker;

  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       eu;
    logic       eo;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;

  logic       result8, eu8, eo8;
  logic [7:0] depth8;
  logic       result2, eu2, eo2;
  logic [1:0] depth2;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  block_nest_checker dut8 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(result8), .depth(depth8),
    .err_underflow(eu8), .err_overflow(eo8)
  );

  block_nest_checker #(.CNT_W(2), .MAX_DEPTH(3)) dut2 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(result2), .depth(depth2),
    .err_underflow(eu2), .err_overflow(eo2)
  );

  task automatic step(input logic [7:0] c, input logic v);
    @(negedge clk);
    in = c;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, got;
    apply_reset();
    e = '{d: 8'd0, r: 1'b1, eu: 1'b0, eo: 1'b0};
    got = {depth8, result8, eu8, eo8};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset8 got=%h exp=%h", got, e);
    end
    got = {6'd0, depth2, result2, eu2, eo2};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset2 got=%h exp=%h", got, e);
    end
    // Reset asserted mid-word, between edges, must act at once
    step("b", 1'b1); step("e", 1'b1); step("g", 1'b1); step("i", 1'b1); step("n", 1'b1);
    checks++;
    if (depth8 !== 8'd1) begin
      failures++;
      $display("FAIL pre_reset_depth got=%0d exp=1", depth8);
    end
    reset = 1'b1;
    #2;
    e = '{d: 8'd0, r: 1'b1, eu: 1'b0, eo: 1'b0};
    got = {depth8, result8, eu8, eo8};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", got, e);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    string s  = "begin end ";
    string ds = "0000111100";
    string rs = "1111000011";
    exp_t  e, got;
    apply_reset();
    for (int i = 0; i < s.len(); i++) begin
      e.d = 8'(ds[i]) - 8'h30;
      e.r = (rs[i] == 8'h31);
      e.eu = 1'b0;
      e.eo = 1'b0;
      sbq.push_back(e);
      step(s[i], 1'b1);
      got = {depth8, result8, eu8, eo8};
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL basic[%0d] got d=%0d r=%0b u=%0b o=%0b exp d=%0d r=%0b u=%0b o=%0b",
                 i, got.d, got.r, got.eu, got.eo, e.d, e.r, e.eu, e.eo);
      end
    end
  endtask

  task automatic test_begin_undo();
    string s  = "begins ";
    string ds = "0000100";
    string rs = "1111011";
    exp_t  e, got;
    apply_reset();
    for (int i = 0; i < s.len(); i++) begin
      e.d = 8'(ds[i]) - 8'h30;
      e.r = (rs[i] == 8'h31);
      e.eu = 1'b0;
      e.eo = 1'b0;
      sbq.push_back(e);
      step(s[i], 1'b1);
      got = {depth8, result8, eu8, eo8};
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL begin_undo[%0d] got d=%0d r=%0b exp d=%0d r=%0b", i, got.d, got.r, e.d, e.r);
      end
    end
  endtask

  task automatic test_end_undo();
    string s  = "begin ends ";
    string ds = "00001111011";
    string rs = "11110000100";
    exp_t  e, got;
    apply_reset();
    for (int i = 0; i < s.len(); i++) begin
      e.d = 8'(ds[i]) - 8'h30;
      e.r = (rs[i] == 8'h31);
      e.eu = 1'b0;
      e.eo = 1'b0;
      sbq.push_back(e);
      step(s[i], 1'b1);
      got = {depth8, result8, eu8, eo8};
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL end_undo[%0d] got d=%0d r=%0b exp d=%0d r=%0b", i, got.d, got.r, e.d, e.r);
      end
    end
  endtask

  task automatic test_underflow();
    string s  = "end begin end ";
    string rs = "11000000000000";
    string us = "00011111111111";
    exp_t  e, got;
    apply_reset();
    for (int i = 0; i < s.len(); i++) begin
      e.d = 8'd0;
      e.r = (rs[i] == 8'h31);
      e.eu = (us[i] == 8'h31);
      e.eo = 1'b0;
      sbq.push_back(e);
      step(s[i], 1'b1);
      got = {depth8, result8, eu8, eo8};
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL underflow[%0d] got d=%0d r=%0b u=%0b exp d=%0d r=%0b u=%0b",
                 i, got.d, got.r, got.eu, e.d, e.r, e.eu);
      end
    end
  endtask

  task automatic test_overflow();
    string s  = "begin begin begin begin end ";
    string ds = {"00001", "1", "11112", "2", "22223", "3", "33333", "3", "333", "3"};
    exp_t  e, got;
    apply_reset();
    for (int i = 0; i < s.len(); i++) begin
      e.d = 8'(ds[i]) - 8'h30;
      e.r = (i < 4);
      e.eu = 1'b0;
      e.eo = (i >= 23);
      sbq.push_back(e);
      step(s[i], 1'b1);
      got = {6'd0, depth2, result2, eu2, eo2};
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL overflow[%0d] got d=%0d r=%0b o=%0b exp d=%0d r=%0b o=%0b",
                 i, got.d, got.r, got.eo, e.d, e.r, e.eo);
      end
    end
  endtask

  task automatic test_valid_toggle();
    string s  = "BeG\niN x EnD ";
    string ds = "0000011111100";
    string rs = "1111100000011";
    exp_t  e, prev, got;
    apply_reset();
    prev = '{d: 8'd0, r: 1'b1, eu: 1'b0, eo: 1'b0};
    for (int i = 0; i < s.len(); i++) begin
      // Idle cycle carrying a keyword letter that must not be consumed
      sbq.push_back(prev);
      step("n", 1'b0);
      got = {depth8, result8, eu8, eo8};
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL toggle_hold[%0d] got d=%0d r=%0b exp d=%0d r=%0b", i, got.d, got.r, e.d, e.r);
      end
      e.d = 8'(ds[i]) - 8'h30;
      e.r = (rs[i] == 8'h31);
      e.eu = 1'b0;
      e.eo = 1'b0;
      sbq.push_back(e);
      prev = e;
      step(s[i], 1'b1);
      got = {depth8, result8, eu8, eo8};
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL toggle[%0d] got d=%0d r=%0b exp d=%0d r=%0b", i, got.d, got.r, e.d, e.r);
      end
    end
  endtask

  task automatic test_digit();
    string s = "end2 ";
`ifdef BLOCK_NEST_DIGIT_EN
    string rs = "11011";
    string us = "00000";
`else
    string rs = "11000";
    string us = "00001";
`endif
    exp_t e, got;
    apply_reset();
    for (int i = 0; i < s.len(); i++) begin
      e.d = 8'd0;
      e.r = (rs[i] == 8'h31);
      e.eu = (us[i] == 8'h31);
      e.eo = 1'b0;
      sbq.push_back(e);
      step(s[i], 1'b1);
      got = {depth8, result8, eu8, eo8};
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL digit[%0d] got r=%0b u=%0b exp r=%0b u=%0b", i, got.r, got.eu, e.r, e.eu);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_begin_undo();
    test_end_undo();
    test_underflow();
    test_overflow();
    test_valid_toggle();
    test_digit();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
